// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : Debug readback engine for the MIPS register file. On a start
//            request it halts the core, then walks every register through the
//            combinational read port and emits {index, data} words over a
//            valid/ready handshake in ascending index order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begins a dump when idle (level, sampled on edge)
//   halt_req   out  asks the core to freeze PC and register writes
//   rd_addr    out  register file read address (registered)
//   rd_data    in   register file read data, combinational from rd_addr
//   dump_valid out  dump_addr/dump_data hold a valid word
//   dump_ready in   consumer accepts the word when high with dump_valid
//   dump_addr  out  index of the emitted register
//   dump_data  out  value of the emitted register
//   busy       out  dump in progress
//   done       out  one-cycle pulse after the last word is accepted
// ============================================================================
module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              halt_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // One extra index bit so a full 2^ADDR_W walk ends without wrapping.
  localparam int              LAST_INT = NUM_REGS - 1;
  localparam logic [ADDR_W:0] LAST_IDX = LAST_INT[ADDR_W:0];

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic [ADDR_W:0]     idx_next;

  assign idx_next = idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_addr_d    = rd_addr_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HALT;
          idx_d     = '0;
          rd_addr_d = '0;
        end
      end
      // Single cycle so the core retires its in-flight instruction before
      // the first read.
      S_HALT: state_d = S_READ;
      S_READ: begin
        dump_data_d  = rd_data;
        dump_addr_d  = idx_q[ADDR_W-1:0];
        dump_valid_d = 1'b1;
        state_d      = S_SEND;
      end
      S_SEND: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_next;
            rd_addr_d = idx_next[ADDR_W-1:0];
            state_d   = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rd_addr_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_addr_q    <= rd_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
    end
  end

  // Status outputs decode straight from the state flop, so an asynchronous
  // reset clears them without waiting for an edge.
  assign busy       = (state_q == S_HALT) || (state_q == S_READ) ||
                      (state_q == S_SEND);
  assign halt_req   = busy;
  assign done       = (state_q == S_DONE);
  assign rd_addr    = rd_addr_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

endmodule
`default_nettype wire
